spi_stream_master: RTL and testbench

Parametrised successor to the single-byte OLED SPI driver. The block buffers a stream of words in a TX FIFO, and each FIFO entry carries its own data/command (DC) bit and end-of-transfer flag. It serialises the words in SPI mode 0 with a programmable SCK divider, holding chip-select low across multi-word bursts. It sits between the SSD1306 init/frame sequencers and the OLED pins, and replaces the per-byte transmit/ready handshake with a valid/ready stream.

---
 rtl/spi_stream_master.sv | 213 +++++++++++++++++++++
 tb/tb_spi_stream_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stream_master.sv
// SPI mode-0 stream master: TX FIFO of {last, dc, data} entries serialised with a
// programmable SCK divider, chip select held low across multi-word bursts.
module spi_stream_master #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int LSB_FIRST  = 0
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_dc,
  input  logic                          wr_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          select,
  output logic                          sck,
  output logic                          mosi,
  output logic                          dc,
  input  logic                          miso,
  output logic [2:0]                    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_NEXT, S_WAIT, S_HOLD, S_GAP
  } state_t;

  // Write side handshake: an entry moves when wr_valid && wr_ready on a clock edge.
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_dc, head_last;

  assign wr_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  assign fifo_empty = (count == '0);
  assign fifo_level = count;
  assign {head_last, head_dc, head_data} = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= {wr_last, wr_dc, wr_data};
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  state_t                state, state_n;
  logic [DW-1:0]         div_cnt, div_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] tx_shift, tx_n, rx_shift, rx_n, rdd_n, tx_next;
  logic                  sck_n, sel_n, mosi_n, dc_n, last_q, last_n, rdv_n;
  logic                  div_done, do_load;

  assign div_done  = (div_cnt == DW'(CLK_DIV - 1));
  assign busy      = !fifo_empty || (state != S_IDLE);
  assign fsm_state = state;
  assign tx_next   = (LSB_FIRST != 0) ? (tx_shift >> 1) : (tx_shift << 1);

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    sck_n   = sck;
    sel_n   = select;
    mosi_n  = mosi;
    dc_n    = dc;
    last_n  = last_q;
    tx_n    = tx_shift;
    rx_n    = rx_shift;
    rdd_n   = rd_data;
    rdv_n   = 1'b0;
    do_load = 1'b0;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        sel_n = 1'b1;
        sck_n = 1'b0;
        if (!fifo_empty) begin
          do_load = 1'b1;
          sel_n   = 1'b0;
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_done) begin
          div_n   = '0;
          state_n = S_SHIFT;
        end else div_n = div_cnt + 1'b1;
      end
      S_SHIFT: begin
        if (!div_done) div_n = div_cnt + 1'b1;
        else begin
          div_n = '0;
          if (!sck) begin
            sck_n = 1'b1;
            rx_n  = (LSB_FIRST != 0) ? {miso, rx_shift[DATA_WIDTH-1:1]}
                                     : {rx_shift[DATA_WIDTH-2:0], miso};
          end else begin
            sck_n = 1'b0;
            // The falling edge after the final bit is the word boundary.
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              rdv_n   = 1'b1;
              rdd_n   = rx_shift;
              state_n = S_NEXT;
            end else begin
              bit_n  = bit_cnt + 1'b1;
              tx_n   = tx_next;
              mosi_n = (LSB_FIRST != 0) ? tx_next[0] : tx_next[DATA_WIDTH-1];
            end
          end
        end
      end
      S_NEXT: begin
        if (last_q) begin
          div_n   = '0;
          state_n = S_HOLD;
        end else if (!fifo_empty) begin
          do_load = 1'b1;
          state_n = S_SHIFT;
        end else state_n = S_WAIT;
      end
      S_WAIT: begin
        if (!fifo_empty) begin
          do_load = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_HOLD: begin
        if (div_done) begin
          div_n   = '0;
          sel_n   = 1'b1;
          state_n = S_GAP;
        end else div_n = div_cnt + 1'b1;
      end
      S_GAP: begin
        if (div_done) begin
          div_n   = '0;
          state_n = S_IDLE;
        end else div_n = div_cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Pops happen only with sck low, so dc never moves under an active clock.
    if (do_load) begin
      pop    = 1'b1;
      tx_n   = head_data;
      mosi_n = (LSB_FIRST != 0) ? head_data[0] : head_data[DATA_WIDTH-1];
      dc_n   = head_dc;
      last_n = head_last;
      div_n  = '0;
      bit_n  = '0;
      sck_n  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b0;
      select   <= 1'b1;
      mosi     <= 1'b0;
      dc       <= 1'b0;
      last_q   <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_cnt  <= bit_n;
      sck      <= sck_n;
      select   <= sel_n;
      mosi     <= mosi_n;
      dc       <= dc_n;
      last_q   <= last_n;
      tx_shift <= tx_n;
      rx_shift <= rx_n;
      rd_data  <= rdd_n;
      rd_valid <= rdv_n;
    end
  end

endmodule

// File: tb/tb_spi_stream_master.sv
// Directed bench for spi_stream_master: MSB-first instance (depth 4) in loopback plus
// an LSB-first loopback instance for wire-order and receive-order checks.
module tb_spi_stream_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_in = 1'b1;
  logic       wr_valid = 1'b0, wr_dc = 1'b0, wr_last = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, busy, rd_valid, select, sck, mosi, dc;
  logic [2:0] fifo_level, fsm_state;
  logic [7:0] rd_data;

  logic       l_valid = 1'b0, l_last = 1'b0;
  logic [7:0] l_data = '0;
  logic       l_ready, l_busy, l_rd_valid, l_select, l_sck, l_mosi, l_dc;
  logic [2:0] l_level, l_state;
  logic [7:0] l_rd_data;

  spi_stream_master #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLK_DIV(4), .LSB_FIRST(0)) u_dut (
    .clk_in(clk), .reset_in(reset_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dc(wr_dc), .wr_last(wr_last), .fifo_level(fifo_level),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .select(select), .sck(sck),
    .mosi(mosi), .dc(dc), .miso(mosi), .fsm_state(fsm_state)
  );

  spi_stream_master #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLK_DIV(4), .LSB_FIRST(1)) u_lsb (
    .clk_in(clk), .reset_in(reset_in), .wr_valid(l_valid), .wr_ready(l_ready),
    .wr_data(l_data), .wr_dc(1'b0), .wr_last(l_last), .fifo_level(l_level),
    .busy(l_busy), .rd_data(l_rd_data), .rd_valid(l_rd_valid), .select(l_select),
    .sck(l_sck), .mosi(l_mosi), .dc(l_dc), .miso(l_mosi), .fsm_state(l_state)
  );

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] l_rx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor statistics, sampled on the falling clk edge.
  int rise_cnt, rv_cnt, bad_hi, hi_len, sel_run, last_sel_run, sel_rises, gap_cnt;
  int max_level, full_viol;
  logic ready_low;
  logic [7:0]  mbits, l_bits;
  logic [15:0] dc_bits;
  logic sck_prev = 1'b0, sel_prev = 1'b1, l_sck_prev = 1'b0;

  task automatic clear_stats();
    rise_cnt = 0; rv_cnt = 0; bad_hi = 0; sel_rises = 0; dc_bits = '0;
    max_level = 0; full_viol = 0; ready_low = 1'b0; last_sel_run = 0;
  endtask

  always @(negedge clk) begin
    if (sck && !sck_prev) begin
      rise_cnt++;
      mbits   = {mbits[6:0], mosi};
      dc_bits = {dc_bits[14:0], dc};
    end
    if (sck) hi_len++;
    else begin
      if (sck_prev && hi_len != 4) bad_hi++;
      hi_len = 0;
    end
    if (!select) sel_run++;
    if (select && !sel_prev) begin
      sel_rises++;
      last_sel_run = sel_run;
      sel_run = 0;
    end
    if (!select) gap_cnt = 0;
    else if (busy) gap_cnt++;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    if (!wr_ready) ready_low = 1'b1;
    if (fifo_level == 3'd4 && wr_ready) full_viol++;
    if (rd_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) check("rx_unexpected", exp_q.size(), 1);
      else check("rx_data", rd_data, exp_q.pop_front());
    end
    if (l_sck && !l_sck_prev) l_bits = {l_bits[6:0], l_mosi};
    if (l_rd_valid) l_rx_q.push_back(l_rd_data);
    sck_prev = sck; sel_prev = select; l_sck_prev = l_sck;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] d, input logic c, input logic l);
    int t = 0;
    wr_valid = 1'b1; wr_data = d; wr_dc = c; wr_last = l;
    while (!wr_ready && t < 1000) begin @(negedge clk); t++; end
    check("push_timeout", t < 1000, 1);
    exp_q.push_back(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    check(tag, t < 3000, 1);
    @(negedge clk);
  endtask

  initial begin
    int t;
    hi_len = 0; sel_run = 0; gap_cnt = 0; mbits = '0; l_bits = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_select", select, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_dc", dc, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_state", fsm_state, 0);
    reset_in = 1'b0;
    @(negedge clk);

    // Single command 0xAE: latency, pulse shape, bit order, select window, CS-high gap.
    clear_stats();
    push(8'hAE, 1'b0, 1'b1);
    t = 0;
    while (!sck && t < 100) begin @(negedge clk); t++; end
    check("first_rise_latency", t, 9);
    wait_idle("single_timeout");
    check("single_rises", rise_cnt, 8);
    check("single_hi_width", bad_hi, 0);
    check("single_mosi_bits", mbits, 8'hAE);
    check("single_dc", dc_bits[7:0], 8'h00);
    check("single_sel_low", last_sel_run, 73);
    check("single_cs_gap", gap_cnt, 4);
    check("single_rv", rv_cnt, 1);

    // Three-word burst: one select window, 65-cycle word period.
    clear_stats();
    push(8'h21, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    push(8'h7F, 1'b0, 1'b1);
    wait_idle("burst_timeout");
    check("burst_rises", rise_cnt, 24);
    check("burst_rv", rv_cnt, 3);
    check("burst_sel_rises", sel_rises, 1);
    check("burst_sel_low", last_sel_run, 4 + 3 * 65 + 4);

    // Loopback 0xA5, 0x3C on the MSB-first instance.
    clear_stats();
    push(8'hA5, 1'b0, 1'b0);
    push(8'h3C, 1'b0, 1'b1);
    wait_idle("loop_timeout");
    check("loop_rv", rv_cnt, 2);
    check("loop_wire_last", mbits, 8'h3C);

    // LSB-first instance: same values back, reversed wire order (0x01 -> 1 first).
    l_valid = 1'b1; l_data = 8'hA5; l_last = 1'b0; @(negedge clk);
    l_data = 8'h3C; @(negedge clk);
    l_data = 8'h01; l_last = 1'b1; @(negedge clk);
    l_valid = 1'b0;
    t = 0;
    while (l_busy && t < 3000) begin @(negedge clk); t++; end
    check("lsb_timeout", t < 3000, 1);
    @(negedge clk);
    check("lsb_rx_count", l_rx_q.size(), 3);
    if (l_rx_q.size() == 3) begin
      check("lsb_rx0", l_rx_q[0], 8'hA5);
      check("lsb_rx1", l_rx_q[1], 8'h3C);
      check("lsb_rx2", l_rx_q[2], 8'h01);
    end
    check("lsb_wire_order", l_bits, 8'h80);

    // Backpressure: six back-to-back writes into a 4-deep FIFO.
    clear_stats();
    for (int i = 1; i <= 6; i++) push({4'(i), 4'(i)}, 1'b0, i == 6);
    wait_idle("bp_timeout");
    check("bp_max_level", max_level, 4);
    check("bp_ready_low", ready_low, 1);
    check("bp_full_ready", full_viol, 0);
    check("bp_rv", rv_cnt, 6);
    check("bp_sel_low", last_sel_run, 4 + 6 * 65 + 4);

    // Underrun: select and sck stay low in WAIT; dc switches before the next word.
    clear_stats();
    push(8'h5A, 1'b0, 1'b0);
    t = 0;
    while (rv_cnt < 1 && t < 1000) begin @(negedge clk); t++; end
    check("ur_first_timeout", t < 1000, 1);
    t = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (select || sck) t++;
    end
    check("ur_wait_lines", t, 0);
    check("ur_state_wait", fsm_state, 4);
    push(8'hC3, 1'b1, 1'b1);
    wait_idle("ur_timeout");
    check("ur_dc_bits", dc_bits, 16'h00FF);
    check("ur_rises", rise_cnt, 16);
    check("ur_sel_rises", sel_rises, 1);
    check("ur_rv", rv_cnt, 2);

    // Reset after the third SCK rise with another entry still queued.
    clear_stats();
    push(8'h96, 1'b0, 1'b0);
    push(8'h55, 1'b0, 1'b1);
    t = 0;
    while (rise_cnt < 3 && t < 200) begin @(negedge clk); t++; end
    check("rst_mid_timeout", t < 200, 1);
    reset_in = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("rst_mid_select", select, 1);
    check("rst_mid_sck", sck, 0);
    check("rst_mid_level", fifo_level, 0);
    check("rst_mid_rd_valid", rd_valid, 0);
    check("rst_mid_state", fsm_state, 0);
    reset_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_rv", rv_cnt, 0);
    clear_stats();
    push(8'hE7, 1'b1, 1'b1);
    wait_idle("post_rst_timeout");
    check("post_rst_rv", rv_cnt, 1);
    check("post_rst_rises", rise_cnt, 8);
    check("post_rst_hi_width", bad_hi, 0);
    check("post_rst_wire", mbits, 8'hE7);
    check("post_rst_sel_low", last_sel_run, 73);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
